pcm_frame_reader: RTL and testbench
===================================

# pcm_frame_reader

Parametrised consumer of the ping-pong audio byte buffer. It reads little-endian PCM bytes from the active buffer half and assembles them into left/right DAC words for 8-, 16- or 24-bit audio with any channel count. It hands frames to the I2S master over a valid/ready handshake and runs the fill/empty handshake with the SD-card producer. It sits between the buffer RAM and `I2S_master`, replacing the fixed 16-bit, 1–2 channel consumer.

## Interface
- `BUFFER_ADDR_BITS`, default 9: width of the buffer byte address.
- `BUFFER_SIZE_BYTES`, default 512: bytes per buffer half.
- `RAM_WAIT_STATES`, default 1: idle cycles between setting an address and sampling the data.
- `DAC_BITS`, default 24: width of the output sample word.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `pause_i` input 1: when high, no new frame fetch starts.
- `buf_addr_o` output `BUFFER_ADDR_BITS`: read byte address.
- `buf_sel_o` output 1: selects the buffer half being read.
- `buf_data_i` input 8: RAM read data.
- `buf_filled_i` input 1: level; the other half holds fresh data.
- `buf_empty_ack_i` input 1: producer has taken the empty request.
- `buf_empty_o` output 1: request to refill the half just released.
- `fmt_bits_i` input 8: bits per sample (8, 16 or 24).
- `fmt_channels_i` input 8: channel count, 1 to 255.
- `frame_L_o` output `DAC_BITS`: left sample word.
- `frame_R_o` output `DAC_BITS`: right sample word.
- `frame_valid_o` output 1: a frame is presented.
- `frame_ready_i` input 1: the I2S master accepts the frame.
- `underrun_o` output 1: buffer exhausted with no fill available.

## Operation
- States:
  - `WAIT_FIRST`: raise `buf_empty_o` until `buf_empty_ack_i`, then go to `WAIT_FILL`.
  - `WAIT_FILL`: on `buf_filled_i`, toggle `buf_sel_o`, set `buf_addr_o`=0, go to `FETCH`.
  - `FETCH`: read bytes of the current frame.
  - `PRESENT`: hold `frame_valid_o` until `frame_ready_i`.
- `FETCH` reads one byte every `RAM_WAIT_STATES`+1 cycles, then increments `buf_addr_o`.
- Bytes per sample B = `fmt_bits_i`/8. Any value other than 8, 16 or 24 is treated as 16.
- Frame length = B × `fmt_channels_i` bytes, little-endian, channel 0 first.
- Channels 0 and 1 are assembled. Bytes of channels 2 and up are read and discarded.
- Mono input: channel 0 is copied to both L and R.
- Word conversion:
  - 8-bit data is unsigned; bit 7 is inverted.
  - The sample is left-justified in `DAC_BITS` and low bits are zero-filled.
  - If the sample is wider than `DAC_BITS`, the LSBs are dropped.
- Buffer end (address `BUFFER_SIZE_BYTES`-1 read):
  - With `buf_filled_i`=1: toggle `buf_sel_o`, wrap the address to 0, set `buf_empty_o`, and continue.
  - Frames may straddle the two halves; partial assembly state is kept across the swap.
  - With `buf_filled_i`=0: set `buf_empty_o`, go to `WAIT_FILL`, assert `underrun_o`. The partial frame is kept.
- `buf_empty_o` clears on the cycle after `buf_empty_ack_i` is sampled high. If ack and a new set occur in the same cycle, the set wins.
- After the last byte of a frame: go to `PRESENT`. On `frame_ready_i`, go back to `FETCH`, unless `pause_i` is high, in which case stay idle in `PRESENT` with valid low.
- `underrun_o` clears when `WAIT_FILL` exits.
- `fmt_*` inputs are sampled at each `WAIT_FILL` exit and are stable otherwise.

## Timing
- Reset values:
  - `buf_addr_o`=0, `buf_sel_o`=0, `buf_empty_o`=0.
  - `frame_L_o`=`frame_R_o`=0, `frame_valid_o`=0, `underrun_o`=0.
  - State `WAIT_FIRST`.
- Reset asserted mid-operation aborts immediately to these values.
- Frame latency from `FETCH` entry to `frame_valid_o`: B·ch·(`RAM_WAIT_STATES`+1) cycles.
- `frame_L_o`/`frame_R_o` are stable while `frame_valid_o` is high. The transfer happens on the cycle where valid and ready are both high.
- `frame_valid_o` is never withdrawn without ready.

## Configuration
- `PCM_READER_UNDERRUN_MUTE_EN` defined:
  - During `WAIT_FILL` after an underrun, the block presents zero frames on `frame_valid_o` so the I2S master keeps clocking silence.
  - The zero frames never carry buffer data.
- Undefined: `frame_valid_o` stays low during an underrun.

## Structure
- The shared package `buffer_pkg` holds:
  - `BUFFER_SIZE_BYTES`, `BUFFER_ADDR_BITS`, `RAM_WAIT_STATES`.
  - The `pcm_reader_state_t` enum.
- One sub-module, `pcm_sample_assembler`:
  - Inputs: byte, byte index, channel index, B.
  - Outputs: left-justified L/R words. Holds the partial frame.
- The top level keeps the state machine, addressing and buffer handshake.

## Test plan
- Stereo 16-bit, bytes 34 12 78 56 → L=0x123400, R=0x567800 (with `DAC_BITS`=24).
- Mono 8-bit, byte 0x00 → L=R=0x800000. Byte 0xFF → L=R=0x7F0000.
- 6-channel 24-bit: channels 2–5 discarded, the address advances by 18 per frame, and one frame straddles the buffer-half boundary intact.
- End of buffer with `buf_filled_i`=0 → `underrun_o`=1 and `buf_empty_o`=1. After fill and ack, the next frame is correct. With the macro defined, zero frames appear meanwhile.
- `frame_ready_i` held low for 50 cycles → the frame holds stable and the address does not advance. `pause_i` high → no fetch after the transfer.
- `rst_n` asserted mid-`FETCH` → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/buffer_pkg.sv
// rtl/buffer_pkg.sv - shared ping-pong buffer geometry and PCM reader state encoding
package buffer_pkg;

  localparam int BUFFER_SIZE_BYTES = 512;
  localparam int BUFFER_ADDR_BITS  = 9;
  localparam int RAM_WAIT_STATES   = 1;

  typedef enum logic [1:0] {
    WAIT_FIRST,
    WAIT_FILL,
    FETCH,
    PRESENT
  } pcm_reader_state_t;

  // Unsupported sample widths fall back to 16-bit.
  function automatic logic [1:0] bytes_per_sample(input logic [7:0] fmt_bits);
    case (fmt_bits)
      8'd8:    return 2'd1;
      8'd24:   return 2'd3;
      default: return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/pcm_sample_assembler.sv
// rtl/pcm_sample_assembler.sv - packs little-endian sample bytes into left-justified L/R words
module pcm_sample_assembler #(
  parameter int DAC_BITS = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  input  logic [1:0]          byte_idx,
  input  logic [7:0]          chan_idx,
  input  logic [1:0]          sample_bytes,
  output logic [DAC_BITS-1:0] word_l,
  output logic [DAC_BITS-1:0] word_r
);

  logic [23:0] acc_l, acc_r, acc_next;
  logic [1:0]  slot;
  logic [7:0]  byte_conv;

  // Bytes land directly in their left-justified slot of a 24-bit word.
  always_comb begin
    slot      = 2'd3 - sample_bytes + byte_idx;
    byte_conv = (sample_bytes == 2'd1) ? {~byte_data[7], byte_data[6:0]} : byte_data;
    acc_next  = (chan_idx == 8'd0) ? acc_l : acc_r;
    if (byte_idx == 2'd0) acc_next = '0;
    case (slot)
      2'd0:    acc_next[7:0]   = byte_conv;
      2'd1:    acc_next[15:8]  = byte_conv;
      default: acc_next[23:16] = byte_conv;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_l <= '0;
      acc_r <= '0;
    end else if (byte_valid) begin
      if (chan_idx == 8'd0)      acc_l <= acc_next;
      else if (chan_idx == 8'd1) acc_r <= acc_next;
    end
  end

  if (DAC_BITS > 24) begin : g_pad
    assign word_l = {acc_l, {(DAC_BITS-24){1'b0}}};
    assign word_r = {acc_r, {(DAC_BITS-24){1'b0}}};
  end else if (DAC_BITS == 24) begin : g_exact
    assign word_l = acc_l;
    assign word_r = acc_r;
  end else begin : g_trunc
    assign word_l = acc_l[23 -: DAC_BITS];
    assign word_r = acc_r[23 -: DAC_BITS];
  end

endmodule

// File: rtl/pcm_frame_reader.sv
// rtl/pcm_frame_reader.sv - ping-pong PCM buffer consumer feeding I2S frames; option PCM_READER_UNDERRUN_MUTE_EN
module pcm_frame_reader #(
  parameter int BUFFER_ADDR_BITS  = buffer_pkg::BUFFER_ADDR_BITS,
  parameter int BUFFER_SIZE_BYTES = buffer_pkg::BUFFER_SIZE_BYTES,
  parameter int RAM_WAIT_STATES   = buffer_pkg::RAM_WAIT_STATES,
  parameter int DAC_BITS          = 24
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pause_i,
  output logic [BUFFER_ADDR_BITS-1:0] buf_addr_o,
  output logic                        buf_sel_o,
  input  logic [7:0]                  buf_data_i,
  input  logic                        buf_filled_i,
  input  logic                        buf_empty_ack_i,
  output logic                        buf_empty_o,
  input  logic [7:0]                  fmt_bits_i,
  input  logic [7:0]                  fmt_channels_i,
  output logic [DAC_BITS-1:0]         frame_L_o,
  output logic [DAC_BITS-1:0]         frame_R_o,
  output logic                        frame_valid_o,
  input  logic                        frame_ready_i,
  output logic                        underrun_o
);

  import buffer_pkg::*;

  localparam logic [BUFFER_ADDR_BITS-1:0] LAST_ADDR = BUFFER_ADDR_BITS'(BUFFER_SIZE_BYTES - 1);
  localparam logic [7:0]                  WAIT_LAST = 8'(RAM_WAIT_STATES);

  pcm_reader_state_t             state, state_d;
  logic [BUFFER_ADDR_BITS-1:0]   addr, addr_d;
  logic                          sel, sel_d, empty, empty_d, empty_set;
  logic                          valid, valid_d, underrun, underrun_d;
  logic                          need_fill, need_fill_d;
  logic [7:0]                    wait_cnt, wait_d, chan_idx, chan_idx_d, channels, channels_d;
  logic [1:0]                    byte_idx, byte_idx_d, bps, bps_d;
  logic                          take_byte, last_in_sample, last_in_frame, muted;
  logic [DAC_BITS-1:0]           word_l, word_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_FIRST;
      addr      <= '0;
      sel       <= 1'b0;
      empty     <= 1'b0;
      valid     <= 1'b0;
      underrun  <= 1'b0;
      need_fill <= 1'b0;
      wait_cnt  <= '0;
      byte_idx  <= '0;
      chan_idx  <= '0;
      bps       <= 2'd2;
      channels  <= 8'd2;
    end else begin
      state     <= state_d;
      addr      <= addr_d;
      sel       <= sel_d;
      empty     <= empty_d;
      valid     <= valid_d;
      underrun  <= underrun_d;
      need_fill <= need_fill_d;
      wait_cnt  <= wait_d;
      byte_idx  <= byte_idx_d;
      chan_idx  <= chan_idx_d;
      bps       <= bps_d;
      channels  <= channels_d;
    end
  end

  always_comb begin
    state_d        = state;
    addr_d         = addr;
    sel_d          = sel;
    valid_d        = valid;
    underrun_d     = underrun;
    need_fill_d    = need_fill;
    wait_d         = '0;
    byte_idx_d     = byte_idx;
    chan_idx_d     = chan_idx;
    bps_d          = bps;
    channels_d     = channels;
    empty_set      = 1'b0;
    take_byte      = 1'b0;
    last_in_sample = (byte_idx == bps - 2'd1);
    last_in_frame  = last_in_sample && (({1'b0, chan_idx} + 9'd1) >= {1'b0, channels});
    case (state)
      WAIT_FIRST: begin
        if (buf_empty_ack_i) state_d = WAIT_FILL;
        else                 empty_set = 1'b1;
      end
      WAIT_FILL: begin
        // A pending silence frame must complete before leaving.
        if (buf_filled_i && (!valid || frame_ready_i)) begin
          state_d     = FETCH;
          sel_d       = ~sel;
          addr_d      = '0;
          valid_d     = 1'b0;
          underrun_d  = 1'b0;
          need_fill_d = 1'b0;
          bps_d       = bytes_per_sample(fmt_bits_i);
          channels_d  = fmt_channels_i;
        end
`ifdef PCM_READER_UNDERRUN_MUTE_EN
        else if (underrun) valid_d = 1'b1;
`endif
      end
      FETCH: begin
        if (wait_cnt == WAIT_LAST) begin
          take_byte  = 1'b1;
          byte_idx_d = last_in_sample ? 2'd0 : byte_idx + 2'd1;
          if (last_in_sample) chan_idx_d = last_in_frame ? 8'd0 : chan_idx + 8'd1;
          if (addr == LAST_ADDR) begin
            empty_set = 1'b1;
            if (buf_filled_i) begin
              sel_d  = ~sel;
              addr_d = '0;
            end else begin
              need_fill_d = 1'b1;
            end
          end else begin
            addr_d = addr + 1'b1;
          end
          // A frame that completes exactly at an unfilled buffer end is presented first.
          if (last_in_frame) begin
            state_d = PRESENT;
            valid_d = 1'b1;
          end else if (addr == LAST_ADDR && !buf_filled_i) begin
            state_d    = WAIT_FILL;
            underrun_d = 1'b1;
          end
        end else begin
          wait_d = wait_cnt + 8'd1;
        end
      end
      PRESENT: begin
        if (valid && frame_ready_i) valid_d = 1'b0;
        if (!pause_i && (!valid || frame_ready_i)) begin
          if (need_fill) begin
            state_d    = WAIT_FILL;
            underrun_d = !buf_filled_i;
          end else begin
            state_d = FETCH;
          end
        end
      end
      default: state_d = WAIT_FIRST;
    endcase
    empty_d = empty_set ? 1'b1 : (buf_empty_ack_i ? 1'b0 : empty);
  end

  pcm_sample_assembler #(.DAC_BITS(DAC_BITS)) u_assembler (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_valid   (take_byte),
    .byte_data    (buf_data_i),
    .byte_idx     (byte_idx),
    .chan_idx     (chan_idx),
    .sample_bytes (bps),
    .word_l       (word_l),
    .word_r       (word_r)
  );

`ifdef PCM_READER_UNDERRUN_MUTE_EN
  assign muted = (state == WAIT_FILL) && underrun;
`else
  assign muted = 1'b0;
`endif

  assign buf_addr_o    = addr;
  assign buf_sel_o     = sel;
  assign buf_empty_o   = empty;
  assign frame_valid_o = valid;
  assign underrun_o    = underrun;
  assign frame_L_o     = muted ? '0 : word_l;
  assign frame_R_o     = muted ? '0 : ((channels == 8'd1) ? word_l : word_r);

endmodule

// File: tb/tb_pcm_frame_reader.sv
// tb/tb_pcm_frame_reader.sv - scoreboard bench for pcm_frame_reader with a 32-byte buffer half
module tb_pcm_frame_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pause_i, buf_sel_o, buf_filled_i, buf_empty_ack_i, buf_empty_o;
  logic        frame_valid_o, frame_ready_i, underrun_o;
  logic [4:0]  buf_addr_o;
  logic [7:0]  buf_data_i, fmt_bits_i, fmt_channels_i;
  logic [23:0] frame_L_o, frame_R_o;
  logic [7:0]  mem [2][32];

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
    logic [4:0]  addr;
    logic        sel;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mute_seen = 0;

  always #5 clk = ~clk;
  assign buf_data_i = mem[buf_sel_o][buf_addr_o];

  pcm_frame_reader #(
    .BUFFER_ADDR_BITS(5), .BUFFER_SIZE_BYTES(32), .RAM_WAIT_STATES(1), .DAC_BITS(24)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pause_i(pause_i),
    .buf_addr_o(buf_addr_o), .buf_sel_o(buf_sel_o), .buf_data_i(buf_data_i),
    .buf_filled_i(buf_filled_i), .buf_empty_ack_i(buf_empty_ack_i), .buf_empty_o(buf_empty_o),
    .fmt_bits_i(fmt_bits_i), .fmt_channels_i(fmt_channels_i),
    .frame_L_o(frame_L_o), .frame_R_o(frame_R_o),
    .frame_valid_o(frame_valid_o), .frame_ready_i(frame_ready_i), .underrun_o(underrun_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void push(input logic [23:0] l, r, input logic [4:0] a, input logic s);
    exp_t e;
    e.l = l; e.r = r; e.addr = a; e.sel = s;
    q.push_back(e);
  endfunction

  // Monitor: compares presented frames against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
`ifdef PCM_READER_UNDERRUN_MUTE_EN
      if (frame_valid_o && underrun_o) begin
        chk("mute_frame", {frame_L_o, frame_R_o}, 64'h0);
        if (frame_ready_i) mute_seen++;
      end
`else
      if (underrun_o) chk("valid_in_underrun", frame_valid_o, 1'b0);
`endif
      if (frame_valid_o && !underrun_o) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=%0h required=none", {frame_L_o, frame_R_o});
        end else if (frame_ready_i) begin
          chk("frame", {frame_L_o, frame_R_o, buf_addr_o, buf_sel_o}, q.pop_front());
        end else begin
          chk("frame_hold", {frame_L_o, frame_R_o, buf_addr_o, buf_sel_o}, q[0]);
        end
      end
    end
  end

  task automatic start(input logic [7:0] bits, input logic [7:0] ch);
    int budget = 20;
    rst_n = 1'b0; pause_i = 1'b0; frame_ready_i = 1'b0; buf_filled_i = 1'b0;
    buf_empty_ack_i = 1'b0; fmt_bits_i = bits; fmt_channels_i = ch;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {buf_addr_o, buf_sel_o, buf_empty_o, frame_L_o, frame_R_o,
                          frame_valid_o, underrun_o}, 64'h0);
    rst_n = 1'b1;
    while (!buf_empty_o && budget > 0) begin @(posedge clk); #1; budget--; end
    chk("first_empty_req", buf_empty_o, 1'b1);
    buf_empty_ack_i = 1'b1;
    @(posedge clk); #1;
    buf_empty_ack_i = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int budget = 500;
    while (!frame_valid_o && budget > 0) begin @(posedge clk); #1; budget--; end
    chk(name, frame_valid_o, 1'b1);
  endtask

  task automatic run_frames(input int n);
    int seen = 0;
    int budget = 2000;
    pause_i = 1'b0; frame_ready_i = 1'b1;
    while (seen < n && budget > 0) begin
      @(posedge clk); #1; budget--;
      if (frame_valid_o && !underrun_o) begin
        seen++;
        if (seen == n) pause_i = 1'b1;
      end
    end
    chk("frames_seen", seen, n);
    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    int budget;
    for (int i = 0; i < 32; i++) begin mem[0][i] = 8'h00; mem[1][i] = 8'h00; end

    // Stereo 16-bit with a long ready stall and a pause after the second frame.
    start(8'd16, 8'd2);
    mem[1][0] = 8'h34; mem[1][1] = 8'h12; mem[1][2] = 8'h78; mem[1][3] = 8'h56;
    mem[1][4] = 8'h00; mem[1][5] = 8'h80; mem[1][6] = 8'hFF; mem[1][7] = 8'h7F;
    push(24'h123400, 24'h567800, 5'd4, 1'b1);
    push(24'h800000, 24'h7FFF00, 5'd8, 1'b1);
    buf_filled_i = 1'b1;
    wait_valid("first_valid");
    repeat (50) @(posedge clk);
    #1;
    chk("stall_addr", buf_addr_o, 5'd4);
    frame_ready_i = 1'b1;
    @(posedge clk); #1;
    frame_ready_i = 1'b0;
    wait_valid("second_valid");
    pause_i = 1'b1; frame_ready_i = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("paused_valid", frame_valid_o, 1'b0);
    chk("paused_addr", buf_addr_o, 5'd8);
    chk("queue_drained", q.size(), 0);

    // Mono 8-bit unsigned.
    start(8'd8, 8'd1);
    mem[1][0] = 8'h00; mem[1][1] = 8'hFF;
    push(24'h800000, 24'h800000, 5'd1, 1'b1);
    push(24'h7F0000, 24'h7F0000, 5'd2, 1'b1);
    buf_filled_i = 1'b1;
    run_frames(2);

    // Six-channel 24-bit; the second frame straddles the half boundary.
    start(8'd24, 8'd6);
    for (int i = 0; i < 32; i++) begin mem[1][i] = 8'(i + 1); mem[0][i] = 8'(8'h40 + i); end
    push(24'h030201, 24'h060504, 5'd18, 1'b1);
    push(24'h151413, 24'h181716, 5'd4,  1'b0);
    push(24'h464544, 24'h494847, 5'd22, 1'b0);
    buf_filled_i = 1'b1;
    run_frames(3);
    chk("swap_empty_req", buf_empty_o, 1'b1);

    // Mono 24-bit underrun mid-frame at the end of the first half.
    start(8'd24, 8'd1);
    for (int i = 0; i < 32; i++) begin mem[1][i] = 8'(i); mem[0][i] = 8'h00; end
    mem[0][0] = 8'hC0;
    for (int k = 0; k < 10; k++)
      push({8'(3*k+2), 8'(3*k+1), 8'(3*k)}, {8'(3*k+2), 8'(3*k+1), 8'(3*k)}, 5'(3*k+3), 1'b1);
    push(24'hC01F1E, 24'hC01F1E, 5'd1, 1'b0);
    buf_filled_i = 1'b1;
    @(posedge clk); #1;
    buf_filled_i = 1'b0;
    frame_ready_i = 1'b1;
    budget = 500;
    while (!underrun_o && budget > 0) begin @(posedge clk); #1; budget--; end
    chk("underrun_flag", underrun_o, 1'b1);
    chk("underrun_empty_req", buf_empty_o, 1'b1);
    chk("underrun_frames_done", q.size(), 1);
    repeat (10) @(posedge clk);
    #1;
    buf_empty_ack_i = 1'b1;
    @(posedge clk); #1;
    buf_empty_ack_i = 1'b0;
    chk("empty_after_ack", buf_empty_o, 1'b0);
    chk("underrun_held", underrun_o, 1'b1);
    buf_filled_i = 1'b1;
    budget = 500;
    while (!(frame_valid_o && !underrun_o) && budget > 0) begin @(posedge clk); #1; budget--; end
    pause_i = 1'b1;
    chk("underrun_cleared", underrun_o, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
`ifdef PCM_READER_UNDERRUN_MUTE_EN
    chk("mute_frames_present", mute_seen > 0, 1'b1);
`endif

    // Asynchronous reset in the middle of a fetch.
    start(8'd16, 8'd2);
    buf_filled_i = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("fetch_addr", {buf_sel_o, buf_addr_o}, {1'b1, 5'd1});
    rst_n = 1'b0;
    #1;
    chk("async_reset", {buf_addr_o, buf_sel_o, buf_empty_o, frame_L_o, frame_R_o,
                        frame_valid_o, underrun_o}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
